// File: rtl/wb_spi_sram_bridge_if.sv
// Wishbone-classic bus bundle between the core master and the SPI memory bridge.
// Latency: none, wires only.
// Backpressure: the slave stalls the master simply by withholding ack_o.
interface wb_spi_sram_bridge_if #(
    parameter int ADR_WIDTH  = 23,
    parameter int DATA_BYTES = 1
);
    logic                      cyc_i;
    logic                      stb_i;
    logic [ADR_WIDTH-1:0]      adr_i;
    logic                      we_i;
    logic [8*DATA_BYTES-1:0]   dat_i;
    logic                      ack_o;
    logic                      err_o;
    logic                      rty_o;
    logic [8*DATA_BYTES-1:0]   dat_o;

    modport master (
        output cyc_i, stb_i, adr_i, we_i, dat_i,
        input  ack_o, err_o, rty_o, dat_o
    );

    modport slave (
        input  cyc_i, stb_i, adr_i, we_i, dat_i,
        output ack_o, err_o, rty_o, dat_o
    );
endinterface

// File: rtl/wb_spi_sram_bridge.sv
// Wishbone-classic slave turning each access into an SPI memory frame (cmd, address, data), MSB-first, mode 0.
// Latency: ack at cycle 1+2*CLK_DIV*N after the strobe is sampled (N = frame bits); deselect gap of >= CLK_DIV cycles after.
// Backpressure: ack is withheld for the whole frame; build with SEQ_BURST_EN to keep ss_n low and continue contiguous accesses.
module wb_spi_sram_bridge #(
    parameter int ADR_WIDTH      = 23,
    parameter int SPI_ADDR_BYTES = 3,
    parameter int DATA_BYTES     = 1,
    parameter int CLK_DIV        = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    wb_spi_sram_bridge_if.slave wb,
    output logic                sck,
    output logic                mosi,
    input  logic                miso,
    output logic                ss_n
);

    localparam int DW    = 8 * DATA_BYTES;
    localparam int AW    = 8 * SPI_ADDR_BYTES;
    localparam int FW    = 8 + AW + DW;
    localparam int BIT_W = $clog2(FW);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BIT_W-1:0] FULL_LAST = BIT_W'(FW - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
`ifdef SEQ_BURST_EN
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DW - 1);
    localparam logic             ACK_SS_N  = 1'b0;
`else
    localparam logic             ACK_SS_N  = 1'b1;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        ACK   = 3'd2,
`ifdef SEQ_BURST_EN
        GAP   = 3'd3,
        HOLD  = 3'd4
`else
        GAP   = 3'd3
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [FW-1:0]      sh_q, sh_d;
    logic [DW-1:0]      rx_q, rx_d;
    logic [DW-1:0]      dat_q, dat_d;
    logic               we_q, we_d;
    logic               sck_q, sck_d;
    logic               ss_n_q, ss_n_d;
    logic               ack_q, ack_d;
    logic               req;
`ifdef SEQ_BURST_EN
    logic [ADR_WIDTH-1:0] adr_q, adr_d;
    logic [ADR_WIDTH-1:0] next_adr;
    logic                 contiguous;
`endif

    // Wire data bytes are sent/received lowest byte first, so the bus word is byte-reversed against the frame.
    function automatic logic [DW-1:0] byte_rev(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            r[8*(DATA_BYTES-1-k) +: 8] = v[8*k +: 8];
        end
        return r;
    endfunction

    // Command, zero-extended address, then data (zeros on reads).
    function automatic logic [FW-1:0] full_frame(input logic we,
                                                 input logic [ADR_WIDTH-1:0] adr,
                                                 input logic [DW-1:0] dat);
        logic [AW-1:0] a;
        a = '0;
        a[ADR_WIDTH-1:0] = adr;
        return {(we ? 8'h02 : 8'h03), a, (we ? byte_rev(dat) : {DW{1'b0}})};
    endfunction

    assign req = wb.cyc_i & wb.stb_i;

`ifdef SEQ_BURST_EN
    assign next_adr   = adr_q + ADR_WIDTH'(DATA_BYTES);
    assign contiguous = (wb.we_i == we_q) && (wb.adr_i == next_adr);
`endif

    // Next-state and datapath decode; every register holds unless a branch below changes it.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        dat_d   = dat_q;
        we_d    = we_q;
        sck_d   = sck_q;
        ss_n_d  = ss_n_q;
        ack_d   = 1'b0;
`ifdef SEQ_BURST_EN
        adr_d   = adr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = wb.we_i;
                    sh_d    = full_frame(wb.we_i, wb.adr_i, wb.dat_i);
                    bit_d   = FULL_LAST;
                    div_d   = '0;
                    sck_d   = 1'b0;
                    ss_n_d  = 1'b0;
                    state_d = SHIFT;
`ifdef SEQ_BURST_EN
                    adr_d   = wb.adr_i;
`endif
                end
            end
            SHIFT: begin
                if (!req) begin
                    // Master gave up: deselect immediately, no ack, read data untouched.
                    sck_d   = 1'b0;
                    ss_n_d  = 1'b1;
                    sh_d    = '0;
                    div_d   = '0;
                    state_d = GAP;
                end else if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[DW-2:0], miso};
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == '0) begin
                            ack_d   = 1'b1;
                            ss_n_d  = ACK_SS_N;
                            sh_d    = '0;
                            state_d = ACK;
                            if (!we_q) begin
                                dat_d = byte_rev(rx_q);
                            end
                        end else begin
                            bit_d = bit_q - BIT_W'(1);
                            sh_d  = {sh_q[FW-2:0], 1'b0};
                        end
                    end
                end
            end
            ACK: begin
                div_d = '0;
`ifdef SEQ_BURST_EN
                if (wb.cyc_i) begin
                    state_d = HOLD;
                end else begin
                    ss_n_d  = 1'b1;
                    state_d = GAP;
                end
`else
                ss_n_d  = 1'b1;
                state_d = GAP;
`endif
            end
            GAP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
`ifdef SEQ_BURST_EN
            HOLD: begin
                if (!wb.cyc_i) begin
                    ss_n_d  = 1'b1;
                    div_d   = '0;
                    state_d = GAP;
                end else if (wb.stb_i) begin
                    if (contiguous) begin
                        // Memory auto-increments: only the data bytes go on the wire.
                        adr_d   = wb.adr_i;
                        sh_d    = {(wb.we_i ? byte_rev(wb.dat_i) : {DW{1'b0}}), {(FW-DW){1'b0}}};
                        bit_d   = DATA_LAST;
                        div_d   = '0;
                        state_d = SHIFT;
                    end else begin
                        // Strobe stays pending and is taken as a full frame once IDLE is reached.
                        ss_n_d  = 1'b1;
                        div_d   = '0;
                        state_d = GAP;
                    end
                end
            end
`endif
            default: begin
                sck_d   = 1'b0;
                ss_n_d  = 1'b1;
                sh_d    = '0;
                div_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sck_q   <= 1'b0;
            ss_n_q  <= 1'b1;
            ack_q   <= 1'b0;
`ifdef SEQ_BURST_EN
            adr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            sck_q   <= sck_d;
            ss_n_q  <= ss_n_d;
            ack_q   <= ack_d;
`ifdef SEQ_BURST_EN
            adr_q   <= adr_d;
`endif
        end
    end

    assign sck       = sck_q;
    assign mosi      = sh_q[FW-1];
    assign ss_n      = ss_n_q;
    assign wb.ack_o  = ack_q;
    assign wb.err_o  = 1'b0;
    assign wb.rty_o  = 1'b0;
    assign wb.dat_o  = dat_q;

endmodule

// File: tb/tb_wb_spi_sram_bridge.sv
// Directed bench for wb_spi_sram_bridge: default instance plus a DATA_BYTES=2, CLK_DIV=3 instance.
// Each SPI slave model shifts a preloaded response out on sck falling edges (mode 0).
// Expected values are hand-derived from the frame format and cycle timing.
module tb_wb_spi_sram_bridge;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_spi_sram_bridge_if #(.ADR_WIDTH(23), .DATA_BYTES(1)) wb1();
    wb_spi_sram_bridge_if #(.ADR_WIDTH(23), .DATA_BYTES(2)) wb2();

    logic sck1, mosi1, ss_n1, miso1;
    logic sck2, mosi2, ss_n2, miso2;
    logic [47:0] resp1, resp2, resp_new1, resp_new2;
    logic load1 = 1'b0, load2 = 1'b0;

`ifdef SEQ_BURST_EN
    localparam logic SSN_AT_ACK = 1'b0;
`else
    localparam logic SSN_AT_ACK = 1'b1;
`endif

    int checks = 0;
    int passes = 0;

    wb_spi_sram_bridge u_dut1 (
        .clk_i (clk), .rst_i (rst), .wb (wb1),
        .sck (sck1), .mosi (mosi1), .miso (miso1), .ss_n (ss_n1)
    );

    wb_spi_sram_bridge #(.ADR_WIDTH(23), .SPI_ADDR_BYTES(3), .DATA_BYTES(2), .CLK_DIV(3)) u_dut2 (
        .clk_i (clk), .rst_i (rst), .wb (wb2),
        .sck (sck2), .mosi (mosi2), .miso (miso2), .ss_n (ss_n2)
    );

    assign miso1 = resp1[47];
    assign miso2 = resp2[47];

    always @(negedge sck1 or posedge load1) begin
        if (load1) resp1 <= resp_new1;
        else       resp1 <= resp1 << 1;
    end

    always @(negedge sck2 or posedge load2) begin
        if (load2) resp2 <= resp_new2;
        else       resp2 <= resp2 << 1;
    end

    task automatic load_resp1(input logic [47:0] v);
        resp_new1 = v;
        load1 = 1'b1;
        #1 load1 = 1'b0;
    endtask

    task automatic load_resp2(input logic [47:0] v);
        resp_new2 = v;
        load2 = 1'b1;
        #1 load2 = 1'b0;
    endtask

    // One access on the default instance; cycle 1 is the first negedge after the strobe is raised.
    task automatic txn1(input logic we, input logic [22:0] adr, input logic [7:0] dat,
                        input logic [47:0] resp, input logic keep_cyc,
                        output int ack_cyc, output int bits, output logic [63:0] cap,
                        output int ssn_hi, output logic ssn_pre, output logic ssn_ack,
                        output logic [7:0] rdata, output logic errs);
        logic prev_sck;
        @(negedge clk);
        ssn_pre = ss_n1;
        load_resp1(resp);
        wb1.cyc_i = 1'b1;
        wb1.stb_i = 1'b1;
        wb1.adr_i = adr;
        wb1.we_i  = we;
        wb1.dat_i = dat;
        ack_cyc = -1; bits = 0; cap = '0; ssn_hi = 0; ssn_ack = 1'b1;
        rdata = '0; errs = 1'b0; prev_sck = 1'b0;
        for (int c = 1; c <= 600 && ack_cyc < 0; c++) begin
            @(negedge clk);
            errs = errs | wb1.err_o | wb1.rty_o;
            if (sck1 && !prev_sck) begin
                cap = {cap[62:0], mosi1};
                bits++;
            end
            prev_sck = sck1;
            if (wb1.ack_o) begin
                ack_cyc = c;
                rdata   = wb1.dat_o;
                ssn_ack = ss_n1;
                wb1.stb_i = 1'b0;
                if (!keep_cyc) wb1.cyc_i = 1'b0;
            end else if (ss_n1) begin
                ssn_hi++;
            end
        end
        if (ack_cyc < 0) begin
            wb1.stb_i = 1'b0;
            wb1.cyc_i = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wb1.cyc_i = 0; wb1.stb_i = 0; wb1.adr_i = '0; wb1.we_i = 0; wb1.dat_i = '0;
        wb2.cyc_i = 0; wb2.stb_i = 0; wb2.adr_i = '0; wb2.we_i = 0; wb2.dat_i = '0;
        load_resp1(48'h0);
        load_resp2(48'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (wb1.ack_o !== 1'b0) $display("FAIL reset_ack: got %b want 0", wb1.ack_o); else passes++;
        checks++; if (ss_n1 !== 1'b1) $display("FAIL reset_ss_n: got %b want 1", ss_n1); else passes++;
        checks++; if (sck1 !== 1'b0) $display("FAIL reset_sck: got %b want 0", sck1); else passes++;
        checks++; if (mosi1 !== 1'b0) $display("FAIL reset_mosi: got %b want 0", mosi1); else passes++;
        checks++; if (wb1.dat_o !== 8'h00) $display("FAIL reset_dat_o: got %h want 00", wb1.dat_o); else passes++;
        checks++; if ((wb1.err_o | wb1.rty_o) !== 1'b0) $display("FAIL reset_err_rty: got %b want 0", wb1.err_o | wb1.rty_o); else passes++;
        checks++; if (ss_n2 !== 1'b1) $display("FAIL reset_ss_n2: got %b want 1", ss_n2); else passes++;
        checks++; if (wb2.dat_o !== 16'h0000) $display("FAIL reset_dat_o2: got %h want 0000", wb2.dat_o); else passes++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write;
        int ack_c, nb, hi; logic [63:0] cap; logic pre, sa, er; logic [7:0] rd;
        txn1(1'b1, 23'h012345, 8'hA5, 48'h0, 1'b0, ack_c, nb, cap, hi, pre, sa, rd, er);
        checks++; if (cap[39:0] !== 40'h02012345A5) $display("FAIL write_mosi: got %h want 02012345a5", cap[39:0]); else passes++;
        checks++; if (nb != 40) $display("FAIL write_bits: got %0d want 40", nb); else passes++;
        checks++; if (ack_c != 81) $display("FAIL write_ack_cycle: got %0d want 81", ack_c); else passes++;
        checks++; if (hi != 0) $display("FAIL write_ss_n_low: got %0d high cycles want 0", hi); else passes++;
        checks++; if (sa !== SSN_AT_ACK) $display("FAIL write_ss_n_at_ack: got %b want %b", sa, SSN_AT_ACK); else passes++;
        checks++; if (er !== 1'b0) $display("FAIL write_err_rty: got %b want 0", er); else passes++;
        @(negedge clk);
        checks++; if (wb1.ack_o !== 1'b0) $display("FAIL write_ack_pulse: got %b want 0", wb1.ack_o); else passes++;
        checks++; if (ss_n1 !== 1'b1) $display("FAIL write_ss_n_after: got %b want 1", ss_n1); else passes++;
    endtask

    task automatic test_read;
        int ack_c, nb, hi; logic [63:0] cap; logic pre, sa, er; logic [7:0] rd;
        txn1(1'b0, 23'h7FFFFF, 8'h00, {32'h0, 8'h3C, 8'h00}, 1'b0, ack_c, nb, cap, hi, pre, sa, rd, er);
        checks++; if (cap[39:8] !== 32'h037FFFFF) $display("FAIL read_cmd_addr: got %h want 037fffff", cap[39:8]); else passes++;
        checks++; if (rd !== 8'h3C) $display("FAIL read_data: got %h want 3c", rd); else passes++;
        checks++; if (ack_c != 81) $display("FAIL read_ack_cycle: got %0d want 81", ack_c); else passes++;
        checks++; if (er !== 1'b0) $display("FAIL read_err_rty: got %b want 0", er); else passes++;
        @(negedge clk);
        checks++; if (wb1.dat_o !== 8'h3C) $display("FAIL read_data_hold: got %h want 3c", wb1.dat_o); else passes++;
    endtask

    task automatic test_wide;
        int ack_c, nb, r1, r2; logic [63:0] cap; logic prev; logic [15:0] rd;
        @(negedge clk);
        load_resp2({32'h0, 8'h5A, 8'hC3});
        wb2.cyc_i = 1'b1; wb2.stb_i = 1'b1; wb2.adr_i = 23'h000ABC; wb2.we_i = 1'b0; wb2.dat_i = '0;
        ack_c = -1; nb = 0; r1 = -1; r2 = -1; cap = '0; prev = 1'b0; rd = '0;
        for (int c = 1; c <= 1000 && ack_c < 0; c++) begin
            @(negedge clk);
            if (sck2 && !prev) begin
                cap = {cap[62:0], mosi2};
                nb++;
                if (r1 < 0) r1 = c;
                else if (r2 < 0) r2 = c;
            end
            prev = sck2;
            if (wb2.ack_o) begin
                ack_c = c;
                rd = wb2.dat_o;
                wb2.stb_i = 1'b0;
                wb2.cyc_i = 1'b0;
            end
        end
        wb2.stb_i = 1'b0;
        wb2.cyc_i = 1'b0;
        checks++; if (ack_c != 289) $display("FAIL wide_ack_cycle: got %0d want 289", ack_c); else passes++;
        checks++; if (nb != 48) $display("FAIL wide_bits: got %0d want 48", nb); else passes++;
        checks++; if (cap[47:16] !== 32'h03000ABC) $display("FAIL wide_cmd_addr: got %h want 03000abc", cap[47:16]); else passes++;
        checks++; if (r2 - r1 != 6) $display("FAIL wide_sck_period: got %0d want 6", r2 - r1); else passes++;
        checks++; if (rd !== 16'hC35A) $display("FAIL wide_data: got %h want c35a", rd); else passes++;
    endtask

    task automatic test_abort;
        int rises, acks; logic hit, prev;
        @(negedge clk);
        load_resp1({32'h0, 8'h99, 8'h00});
        wb1.cyc_i = 1'b1; wb1.stb_i = 1'b1; wb1.adr_i = 23'h000042; wb1.we_i = 1'b0; wb1.dat_i = '0;
        rises = 0; hit = 1'b0; prev = 1'b0;
        for (int c = 1; c <= 400 && !hit; c++) begin
            @(negedge clk);
            if (sck1 && !prev) rises++;
            prev = sck1;
            if (rises == 20) begin
                hit = 1'b1;
                wb1.cyc_i = 1'b0;
                wb1.stb_i = 1'b0;
            end
        end
        wb1.cyc_i = 1'b0;
        wb1.stb_i = 1'b0;
        checks++; if (hit !== 1'b1) $display("FAIL abort_reach_bit20: got %0d rises want 20", rises); else passes++;
        @(negedge clk);
        checks++; if (ss_n1 !== 1'b1) $display("FAIL abort_ss_n: got %b want 1", ss_n1); else passes++;
        checks++; if (sck1 !== 1'b0) $display("FAIL abort_sck: got %b want 0", sck1); else passes++;
        acks = 0;
        repeat (100) begin
            @(negedge clk);
            if (wb1.ack_o) acks++;
        end
        checks++; if (acks != 0) $display("FAIL abort_no_ack: got %0d acks want 0", acks); else passes++;
        checks++; if (wb1.dat_o !== 8'h3C) $display("FAIL abort_dat_hold: got %h want 3c", wb1.dat_o); else passes++;

        load_resp1({32'h0, 8'h77, 8'h00});
        wb1.cyc_i = 1'b1; wb1.stb_i = 1'b1; wb1.adr_i = 23'h000010; wb1.we_i = 1'b0;
        repeat (50) @(negedge clk);
        checks++; if (ss_n1 !== 1'b0) $display("FAIL rst_midframe_active: got ss_n %b want 0", ss_n1); else passes++;
        rst = 1'b1;
        wb1.cyc_i = 1'b0; wb1.stb_i = 1'b0;
        @(negedge clk);
        checks++; if (ss_n1 !== 1'b1) $display("FAIL rst_ss_n: got %b want 1", ss_n1); else passes++;
        checks++; if (sck1 !== 1'b0) $display("FAIL rst_sck: got %b want 0", sck1); else passes++;
        checks++; if (mosi1 !== 1'b0) $display("FAIL rst_mosi: got %b want 0", mosi1); else passes++;
        checks++; if (wb1.ack_o !== 1'b0) $display("FAIL rst_ack: got %b want 0", wb1.ack_o); else passes++;
        checks++; if (wb1.dat_o !== 8'h00) $display("FAIL rst_dat_o: got %h want 00", wb1.dat_o); else passes++;
        rst = 1'b0;
        acks = 0;
        repeat (20) begin
            @(negedge clk);
            if (wb1.ack_o) acks++;
        end
        checks++; if (acks != 0) $display("FAIL rst_no_ack: got %0d acks want 0", acks); else passes++;
    endtask

    task automatic test_back_to_back;
        int a_ack, a_nb, a_hi, b_ack, b_nb, b_hi, c_ack, c_nb, c_hi;
        logic [63:0] a_cap, b_cap, c_cap;
        logic a_pre, a_sa, a_er, b_pre, b_sa, b_er, c_pre, c_sa, c_er;
        logic [7:0] a_rd, b_rd, c_rd;
        logic [47:0] b_resp;
`ifdef SEQ_BURST_EN
        b_resp = {8'h22, 40'h0};
`else
        b_resp = {32'h0, 8'h22, 8'h00};
`endif
        txn1(1'b0, 23'h000100, 8'h00, {32'h0, 8'h11, 8'h00}, 1'b1, a_ack, a_nb, a_cap, a_hi, a_pre, a_sa, a_rd, a_er);
        txn1(1'b0, 23'h000101, 8'h00, b_resp, 1'b1, b_ack, b_nb, b_cap, b_hi, b_pre, b_sa, b_rd, b_er);
        txn1(1'b0, 23'h000200, 8'h00, {32'h0, 8'h33, 8'h00}, 1'b0, c_ack, c_nb, c_cap, c_hi, c_pre, c_sa, c_rd, c_er);
        checks++; if (a_ack != 81) $display("FAIL seq1_ack_cycle: got %0d want 81", a_ack); else passes++;
        checks++; if (a_cap[39:8] !== 32'h03000100) $display("FAIL seq1_cmd_addr: got %h want 03000100", a_cap[39:8]); else passes++;
        checks++; if (a_rd !== 8'h11) $display("FAIL seq1_data: got %h want 11", a_rd); else passes++;
        checks++; if (b_rd !== 8'h22) $display("FAIL seq2_data: got %h want 22", b_rd); else passes++;
`ifdef SEQ_BURST_EN
        checks++; if (b_nb != 8) $display("FAIL seq2_bits: got %0d want 8", b_nb); else passes++;
        checks++; if (b_ack != 17) $display("FAIL seq2_ack_cycle: got %0d want 17", b_ack); else passes++;
        checks++; if ((b_pre | b_sa | (b_hi != 0)) !== 1'b0) $display("FAIL seq2_ss_n_low: got pre %b ack %b high %0d want all low", b_pre, b_sa, b_hi); else passes++;
`else
        checks++; if (b_nb != 40) $display("FAIL seq2_bits: got %0d want 40", b_nb); else passes++;
        checks++; if (b_cap[39:8] !== 32'h03000101) $display("FAIL seq2_cmd_addr: got %h want 03000101", b_cap[39:8]); else passes++;
        checks++; if (b_hi < 1) $display("FAIL seq2_gap: got %0d high cycles want >=1", b_hi); else passes++;
`endif
        checks++; if (c_nb != 40) $display("FAIL seq3_bits: got %0d want 40", c_nb); else passes++;
        checks++; if (c_cap[39:8] !== 32'h03000200) $display("FAIL seq3_cmd_addr: got %h want 03000200", c_cap[39:8]); else passes++;
        checks++; if (c_hi < 1) $display("FAIL seq3_gap: got %0d high cycles want >=1", c_hi); else passes++;
        checks++; if (c_rd !== 8'h33) $display("FAIL seq3_data: got %h want 33", c_rd); else passes++;
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_wide;
        test_abort;
        test_back_to_back;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion want finish before timeout");
        $fatal(1);
    end

endmodule

// File: doc/wb_spi_sram_bridge.md
Name: wb_spi_sram_bridge

Overview:
Parametrised Wishbone-classic slave that turns each bus access into a serial SRAM/flash-style SPI transaction: command byte (READ 0x03 / WRITE 0x02), address bytes, data bytes. Generalises the existing single-byte bridge with the following additions:
- configurable address width, data width and SCK divider;
- MSB-first framing;
- clean abort and deselect-gap handling;
- optional sequential-burst continuation.
Sits between the core's Wishbone master and the external SPI memory pins.

Parameters:
- ADR_WIDTH, 23: Wishbone byte-address width; zero-extended into the SPI address field.
- SPI_ADDR_BYTES, 3: address bytes sent; must satisfy 8*SPI_ADDR_BYTES >= ADR_WIDTH.
- DATA_BYTES, 1: bytes per access. The bus data width is 8*DATA_BYTES.
- CLK_DIV, 1: clk_i cycles per SCK half-period; must be >= 1.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- cyc_i  in  1  Wishbone cycle
- stb_i  in  1  Wishbone strobe
- adr_i  in  ADR_WIDTH  byte address of lowest data byte
- we_i  in  1  1 = write, 0 = read
- dat_i  in  8*DATA_BYTES  write data
- ack_o  out  1  single-cycle acknowledge
- err_o  out  1  tied 0
- rty_o  out  1  tied 0
- dat_o  out  8*DATA_BYTES  read data
- sck  out  1  SPI clock, mode 0
- mosi  out  1  SPI data out
- miso  in  1  SPI data in
- ss_n  out  1  active-low chip select

Behaviour:
- One clock (clk_i); reset rst_i is synchronous, active-high.
- Reset values: ack_o=0, ss_n=1, sck=0, mosi=0, dat_o=0. State = IDLE. Divider and bit counter = 0.
- States: IDLE, SHIFT, ACK, GAP, plus HOLD (burst build only).
- IDLE: when cyc_i & stb_i are high, latch adr_i, we_i and dat_i, then go to SHIFT. Later changes on those inputs are ignored until ack.
- SHIFT: ss_n=0. Frame of N bits is sent MSB-first, with N = 8*(1+SPI_ADDR_BYTES+DATA_BYTES).
  - Byte order: command byte, then address (zero-extended, MSB byte first), then data.
  - Data byte k comes from dat_i[8k+7:8k], k=0 first.
- Bit timing:
  - Each bit uses a low half then a high half of sck, each CLK_DIV cycles.
  - mosi changes only while sck is low, at the start of the low half.
  - miso is sampled on the clk_i edge that raises sck.
  - Read data byte k is assembled into dat_o[8k+7:8k]. dat_o updates only on reads and holds otherwise.
- Latency (non-burst):
  - Strobe sampled at cycle 0; ss_n falls at cycle 1 with mosi = bit 0.
  - ack_o=1 at cycle 1+2*CLK_DIV*N, with sck=0 and ss_n=1 in that same cycle.
  - Default parameters: N=40, ack at cycle 81.
- ACK: ack_o is high for exactly one cycle. Then go to GAP, or HOLD when the burst feature is built in and cyc_i is still high.
- GAP: ss_n=1 for at least CLK_DIV cycles, then IDLE. A strobe arriving during GAP waits; it is never lost.
- Abort: cyc_i or stb_i falling during SHIFT causes, on the next edge, ss_n=1, sck=0, no ack, dat_o unchanged, then GAP.
- Reset mid-transfer: all outputs take reset values on that edge; no ack is issued.
- After ack, a new strobe is required. The cycle after ack is never treated as a new request unless stb_i is still high with IDLE/HOLD reached (back-to-back accesses are legal).

Optional Feature:
SEQ_BURST_EN.
- Defined:
  - After ACK with cyc_i high, enter HOLD: ss_n=0, sck=0.
  - Contiguous strobe (same we_i, adr_i == previous adr + DATA_BYTES, modulo 2^ADR_WIDTH): shift data bytes only, N=8*DATA_BYTES. Ack at cycle 1+2*CLK_DIV*8*DATA_BYTES; ss_n stays low through ack.
  - Non-contiguous strobe: ss_n=1, GAP, then full frame.
  - cyc_i falling in HOLD: ss_n=1 next edge, then GAP.
- Undefined: HOLD does not exist; every access is a full frame with GAP.

Test Plan:
- Defaults, write adr=0x12345 dat=0xA5 -> mosi stream 02 01 23 45 A5 MSB-first; ss_n low for cycles 1..80; ack_o single pulse at cycle 81.
- Defaults, read adr=0x7FFFFF, miso model returns 0x3C -> command 03 7F FF FF; dat_o=0x3C at ack; err_o=rty_o=0 throughout.
- DATA_BYTES=2, CLK_DIV=3, read -> N=48; ack at cycle 289; first miso byte lands in dat_o[7:0]; sck period 6 cycles.
- Drop cyc_i at bit 20, then rst_i pulse mid-frame -> ss_n=1 next edge, no ack, dat_o unchanged; reset forces all outputs to reset values.
- SEQ_BURST_EN: reads at 0x100, then 0x101, then 0x200 within one cycle -> second read shifts 8 bits only, ack at cycle 17, ss_n never rises; third read raises ss_n ≥1 cycle, then sends a full 03 00 02 00 frame.
- Without SEQ_BURST_EN, same sequence -> three full 40-bit frames, each separated by ss_n high for ≥ CLK_DIV cycles.
